// File: rtl/urv_imem_arbiter_pkg.sv
// Shared types and defaults for the instruction-RAM arbiter slice.
// Optional host-lock feature is enabled by defining URV_IMEM_ARB_HOST_LOCK_EN.
package urv_imem_arbiter_pkg;

  localparam int unsigned HOST_WAIT_DEF = 3;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HACK  = 1'b1
  } arb_state_t;

  // Counter width able to hold max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/urv_imem_starve_cnt.sv
// Saturating count of consecutive cycles a pending host request was denied.
module urv_imem_starve_cnt
  import urv_imem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = HOST_WAIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned W = cnt_width(MAX);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sat = (cnt_q == W'(MAX));

endmodule

// File: rtl/urv_imem_arbiter.sv
// Per-cycle arbiter sharing one synchronous instruction RAM between fetch and a host port.
// Define URV_IMEM_ARB_HOST_LOCK_EN to add h_lock_i (host wins every fetch-state cycle).
module urv_imem_arbiter
  import urv_imem_arbiter_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter int unsigned HOST_WAIT = HOST_WAIT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   im_addr_i,
  output logic [31:0]   im_data_o,
  output logic          im_valid_o,
  input  logic          h_req_i,
  input  logic          h_we_i,
  input  logic [31:0]   h_addr_i,
  input  logic [31:0]   h_wdata_i,
  input  logic [3:0]    h_wsel_i,
`ifdef URV_IMEM_ARB_HOST_LOCK_EN
  input  logic          h_lock_i,
`endif
  output logic          h_ack_o,
  output logic [31:0]   h_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_wr_o,
  input  logic [31:0]   mem_rdata_i
);

  arb_state_t state_q, state_d;
  logic       host_lock;
  logic       host_win;
  logic       starve_inc;
  logic       starve_sat;
  logic       im_valid_q;
  logic       hack_we_q;
  logic       unused_addr_bits;

`ifdef URV_IMEM_ARB_HOST_LOCK_EN
  assign host_lock = h_lock_i;
`else
  assign host_lock = 1'b0;
`endif

  // Address bits outside the RAM word index alias by design.
  assign unused_addr_bits = ^{im_addr_i[31:AW+2], im_addr_i[1:0],
                              h_addr_i[31:AW+2], h_addr_i[1:0]};

  always_comb begin
    state_d    = S_FETCH;
    host_win   = 1'b0;
    starve_inc = 1'b0;
    mem_addr_o = im_addr_i[AW+1:2];
    mem_wr_o   = '0;
    if (state_q == S_FETCH) begin
      if (h_req_i && (starve_sat || host_lock)) begin
        host_win   = 1'b1;
        state_d    = S_HACK;
        mem_addr_o = h_addr_i[AW+1:2];
        // A write granted in a reset cycle must never reach the RAM.
        if (h_we_i && !rst_i) begin
          mem_wr_o = h_wsel_i;
        end
      end else begin
        starve_inc = h_req_i;
      end
    end
  end

  urv_imem_starve_cnt #(
    .MAX (HOST_WAIT)
  ) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (starve_inc),
    .clr   (!starve_inc),
    .sat   (starve_sat)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      im_valid_q <= 1'b0;
      hack_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      im_valid_q <= !host_win;
      hack_we_q  <= h_we_i;
    end
  end

  assign mem_wdata_o = h_wdata_i;
  assign im_data_o   = mem_rdata_i;
  assign im_valid_o  = im_valid_q;
  assign h_ack_o     = (state_q == S_HACK);
  assign h_rdata_o   = (h_ack_o && !hack_we_q) ? mem_rdata_i : '0;

endmodule
